// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store initiator between the CPU memory stage and a
// word-wide data memory. One byte/half/word access per handshake, turned
// into word-aligned memory transactions. Sub-word stores are performed as
// read-modify-write. Misaligned accesses respond with resp_err and never
// touch memory. Loads are sign- or zero-extended.
//
// Ports:
//   clk, reset (sync, active-low)
//   req_valid/req_ready handshake; req_we, req_size, req_unsigned,
//   req_addr, req_wdata describe the access
//   resp_valid (1-cycle pulse), resp_rdata, resp_err
//   mem_req, mem_we, mem_addr (word aligned), mem_wdata, mem_ack, mem_rdata
module lsu_mem_port (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state;
  logic        lat_we;
  logic        lat_uns;
  logic [1:0]  lat_size;
  logic [1:0]  lat_off;
  logic [15:0] lat_wdata;   // only the sub-word part is needed after acceptance

  logic        misalign;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] merged;

  // Size 11 behaves as a word, so bit 1 alone identifies a word access.
  always_comb begin
    misalign = 1'b0;
    if (req_size[1])
      misalign = (req_addr[1:0] != 2'b00);
    else if (req_size[0])
      misalign = req_addr[0];
  end

  // Lane extraction and store merge, from the memory word and latched request.
  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (lat_off)
      2'd0: byte_sel = mem_rdata[7:0];
      2'd1: byte_sel = mem_rdata[15:8];
      2'd2: byte_sel = mem_rdata[23:16];
      2'd3: byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    if (lat_size[1])
      load_data = mem_rdata;
    else if (lat_size[0])
      load_data = {{16{~lat_uns & half_sel[15]}}, half_sel};
    else
      load_data = {{24{~lat_uns & byte_sel[7]}}, byte_sel};

    merged = mem_rdata;
    if (lat_size[0]) begin
      if (lat_off[1]) merged[31:16] = lat_wdata;
      else            merged[15:0]  = lat_wdata;
    end else begin
      case (lat_off)
        2'd0: merged[7:0]   = lat_wdata[7:0];
        2'd1: merged[15:8]  = lat_wdata[7:0];
        2'd2: merged[23:16] = lat_wdata[7:0];
        2'd3: merged[31:24] = lat_wdata[7:0];
        default: merged = mem_rdata;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      lat_we     <= 1'b0;
      lat_uns    <= 1'b0;
      lat_size   <= '0;
      lat_off    <= '0;
      lat_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            lat_we    <= req_we;
            lat_uns   <= req_unsigned;
            lat_size  <= req_size;
            lat_off   <= req_addr[1:0];
            lat_wdata <= req_wdata[15:0];
            mem_addr  <= {req_addr[31:2], 2'b00};
            if (misalign) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else if (req_we && req_size[1]) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
              state     <= WR;
            end else begin
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
              state   <= RD;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        RD: begin
          if (mem_ack) begin
            if (lat_we) begin
              // RMW: mem_req stays high and the same word is written next.
              mem_we    <= 1'b1;
              mem_wdata <= merged;
              state     <= WR;
            end else begin
              mem_req    <= 1'b0;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= load_data;
              state      <= RESP;
            end
          end
        end
        WR: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            state      <= RESP;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Testbench for lsu_mem_port: table of directed accesses against a small
// word memory with configurable read stall, plus hand sequences for reset,
// mid-RMW reset and back-to-back requests.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_port dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  // Memory model
  logic [31:0] mem [0:15];
  int          stall_cfg = 0;
  logic        wr_hold = 1'b0;
  logic        stray = 1'b0;
  int          wait_cnt = 0;
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  assign mem_rdata = mem[mem_addr[5:2]];
  assign mem_ack = stray | (mem_req & (mem_we ? ~wr_hold : (wait_cnt >= stall_cfg)));

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_req && mem_we && mem_ack) mem[mem_addr[5:2]] <= mem_wdata;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_nreq;
    logic [3:0]  exp_seq;
    logic        chk_mem;
    int          mem_idx;
    logic [31:0] mem_exp;
  } vec_t;

  function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                              logic [31:0] wdata, int stall, logic [31:0] er, logic ee,
                              int lat, int nreq, logic [3:0] seq, logic cm, int mi,
                              logic [31:0] me);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.stall = stall; v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat;
    v.exp_nreq = nreq; v.exp_seq = seq; v.chk_mem = cm; v.mem_idx = mi; v.mem_exp = me;
    return v;
  endfunction

  task automatic wait_ready(input int id);
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", id, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int lat = 0;
    int nreq = 0;
    logic [3:0] seq = '0;
    logic rdy_ok = 1'b1;
    logic addr_ok = 1'b1;
    logic [31:0] got_rdata = '0;
    logic got_err = 1'b0;
    wait_ready(id);
    stall_cfg = v.stall;
    req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_req) begin
        nreq++;
        seq = {seq[2:0], mem_we};
        if (mem_addr !== {v.addr[31:2], 2'b00}) addr_ok = 1'b0;
      end
      if (req_ready) rdy_ok = 1'b0;
      if (resp_valid) begin
        lat = c;
        got_rdata = resp_rdata;
        got_err = resp_err;
        break;
      end
    end
    chk("latency", id, lat, v.exp_lat);
    chk("rdata", id, got_rdata, v.exp_rdata);
    chk("err", id, {31'd0, got_err}, {31'd0, v.exp_err});
    chk("mem_req_cycles", id, nreq, v.exp_nreq);
    chk("mem_we_seq", id, {28'd0, seq}, {28'd0, v.exp_seq});
    chk("ready_low", id, {31'd0, rdy_ok}, 32'd1);
    chk("addr_stable", id, {31'd0, addr_ok}, 32'd1);
    if (v.chk_mem) chk("mem_word", id, mem[v.mem_idx], v.mem_exp);
    @(negedge clk);
    chk("pulse_ready", id, {30'd0, resp_valid, req_ready}, 32'd1);
    stall_cfg = 0;
  endtask

  vec_t vecs [18];
  int resp_cyc [2];
  logic [31:0] resp_dat [2];

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk(0, 2'd0, 0, 32'h10, 32'h0,        0, 32'hFFFF_FFF0, 0, 2, 1, 4'b0000, 0, 0, 0);
    vecs[1]  = mk(0, 2'd0, 1, 32'h10, 32'h0,        0, 32'h0000_00F0, 0, 2, 1, 4'b0000, 0, 0, 0);
    vecs[2]  = mk(0, 2'd1, 0, 32'h12, 32'h0,        0, 32'hFFFF_8000, 0, 2, 1, 4'b0000, 0, 0, 0);
    vecs[3]  = mk(0, 2'd1, 1, 32'h12, 32'h0,        0, 32'h0000_8000, 0, 2, 1, 4'b0000, 0, 0, 0);
    vecs[4]  = mk(0, 2'd2, 0, 32'h10, 32'h0,        0, 32'h8000_00F0, 0, 2, 1, 4'b0000, 0, 0, 0);
    vecs[5]  = mk(0, 2'd0, 0, 32'h13, 32'h0,        0, 32'hFFFF_FF80, 0, 2, 1, 4'b0000, 0, 0, 0);
    vecs[6]  = mk(0, 2'd3, 1, 32'h10, 32'h0,        0, 32'h8000_00F0, 0, 2, 1, 4'b0000, 0, 0, 0);
    vecs[7]  = mk(1, 2'd0, 0, 32'h21, 32'hFFFF_FFAB, 0, 32'h0,        0, 3, 2, 4'b0001, 1, 8, 32'h1122_AB44);
    vecs[8]  = mk(1, 2'd1, 0, 32'h22, 32'h1234_BEEF, 0, 32'h0,        0, 3, 2, 4'b0001, 1, 8, 32'hBEEF_AB44);
    vecs[9]  = mk(0, 2'd2, 0, 32'h20, 32'h0,        0, 32'hBEEF_AB44, 0, 2, 1, 4'b0000, 0, 0, 0);
    vecs[10] = mk(1, 2'd2, 0, 32'h24, 32'h0BAD_F00D, 0, 32'h0,        0, 2, 1, 4'b0001, 1, 9, 32'h0BAD_F00D);
    vecs[11] = mk(0, 2'd2, 0, 32'h06, 32'h0,        0, 32'h0,        1, 1, 0, 4'b0000, 0, 0, 0);
    vecs[12] = mk(1, 2'd1, 0, 32'h03, 32'h0000_FFFF, 0, 32'h0,        1, 1, 0, 4'b0000, 1, 0, 32'h0102_0304);
    vecs[13] = mk(0, 2'd2, 0, 32'h04, 32'h0,        3, 32'hCAFE_F00D, 0, 5, 4, 4'b0000, 0, 0, 0);
    vecs[14] = mk(0, 2'd1, 0, 32'h06, 32'h0,        0, 32'hFFFF_CAFE, 0, 2, 1, 4'b0000, 0, 0, 0);
    vecs[15] = mk(0, 2'd1, 1, 32'h06, 32'h0,        0, 32'h0000_CAFE, 0, 2, 1, 4'b0000, 0, 0, 0);
    vecs[16] = mk(1, 2'd0, 0, 32'h11, 32'h0000_005A, 2, 32'h0,        0, 5, 4, 4'b0001, 1, 4, 32'h8000_5AF0);
    vecs[17] = mk(0, 2'd0, 1, 32'h11, 32'h0,        0, 32'h0000_005A, 0, 2, 1, 4'b0000, 0, 0, 0);

    // Reset: preload memory while held in reset, then check outputs.
    preload(4'd0, 32'h0102_0304);
    preload(4'd1, 32'hCAFE_F00D);
    preload(4'd4, 32'h8000_00F0);
    preload(4'd8, 32'h1122_3344);
    preload(4'd10, 32'h5566_7788);
    @(negedge clk);
    chk("reset_ctl", 0, {27'd0, req_ready, resp_valid, resp_err, mem_req, mem_we}, 32'd0);
    chk("reset_rdata", 0, resp_rdata, 32'd0);
    chk("reset_maddr", 0, mem_addr, 32'd0);
    chk("reset_mwdata", 0, mem_wdata, 32'd0);

    // Release; stray mem_ack while idle must be ignored.
    reset = 1'b1;
    stray = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 0, {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("stray_ack", 0, {29'd0, resp_valid, mem_req, req_ready}, 32'd1);
    stray = 1'b0;

    for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

    // Reset while the RMW write phase is stalled.
    wr_hold = 1'b1;
    wait_ready(100);
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h28; req_wdata = 32'h99; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    begin
      int w = 0;
      @(negedge clk);
      while (!(mem_req && mem_we) && w < 10) begin
        @(negedge clk);
        w++;
      end
      chk("reach_wr", 100, {31'd0, mem_req & mem_we}, 32'd1);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_ctl", 100, {27'd0, req_ready, resp_valid, resp_err, mem_req, mem_we}, 32'd0);
    chk("midrst_bus", 100, resp_rdata | mem_addr | mem_wdata, 32'd0);
    chk("midrst_mem", 100, mem[10], 32'h5566_7788);
    wr_hold = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 100, {31'd0, req_ready}, 32'd1);
    run_vec(mk(0, 2'd2, 0, 32'h10, 32'h0, 0, 32'h8000_5AF0, 0, 2, 1, 4'b0000, 0, 0, 0), 101);

    // Back-to-back: req_valid held high across two loads.
    begin
      int nresp = 0;
      int acc = 0;
      logic drop = 1'b0;
      wait_ready(200);
      req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h24; req_valid = 1'b1;
      @(posedge clk);
      #1 req_addr = 32'h04;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (resp_valid && nresp < 2) begin
          resp_cyc[nresp] = c;
          resp_dat[nresp] = resp_rdata;
          nresp++;
        end else if (resp_valid) begin
          nresp++;
        end
        if (req_ready && req_valid && acc == 0) begin
          acc = c;
          drop = 1'b1;
        end
        @(posedge clk);
        #1 if (drop) req_valid = 1'b0;
      end
      chk("b2b_nresp", 200, nresp, 2);
      chk("b2b_accept", 200, acc, 3);
      chk("b2b_cyc0", 200, resp_cyc[0], 2);
      chk("b2b_dat0", 200, resp_dat[0], 32'h0BAD_F00D);
      chk("b2b_cyc1", 200, resp_cyc[1], 5);
      chk("b2b_dat1", 200, resp_dat[1], 32'hCAFE_F00D);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
